// File: rtl/frame_pkg.sv
// Shared state codes for the frame sequence checker.
// Latency: none (definitions only).
// Backpressure: not applicable.
package frame_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] FIRST_PKT = 3'd1;
  localparam logic [STATE_W-1:0] REG_PKT   = 3'd2;
  localparam logic [STATE_W-1:0] HDR_ERR   = 3'd3;
  localparam logic [STATE_W-1:0] SEQ_ERR   = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE      = IDLE,
    S_FIRST_PKT = FIRST_PKT,
    S_REG_PKT   = REG_PKT,
    S_HDR_ERR   = HDR_ERR,
    S_SEQ_ERR   = SEQ_ERR
  } state_t;

  // True for the two states that mean the stream is out of sync.
  function automatic logic is_err_state(input state_t s);
    return (s == S_HDR_ERR) || (s == S_SEQ_ERR);
  endfunction

endpackage

// File: rtl/frame_seq_checker_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Latency: count updates on the edge that samples inc/clr.
// Backpressure: none; clear beats a simultaneous increment, holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  // Clear has priority; increment stops once every bit is set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/frame_seq_checker.sv
// Checks header field and rolling sequence number of each qualified word; forwards good words.
// Latency: 1 cycle, all outputs registered on the edge that samples the word.
// Backpressure: none; in_valid low freezes state, drops out_valid and holds bus_out.
module frame_seq_checker
  import frame_pkg::*;
#(
  parameter int                BUS_W      = 16,
  parameter int                HDR_W      = 4,
  parameter logic [HDR_W-1:0]  HDR_VAL    = 4'hF,
  parameter int                SEQ_W      = 4,
  parameter int                CNT_W      = 8,
  parameter bit                RESYNC_ANY = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [BUS_W-1:0]   bus_in,
  input  logic               in_valid,
  input  logic               err_clr,
  output logic [BUS_W-1:0]   bus_out,
  output logic               out_valid,
  output logic [STATE_W-1:0] control,
  output logic               error,
  output logic [SEQ_W-1:0]   expected_seq,
  output logic [CNT_W-1:0]   err_count
);

  state_t           state;
  state_t           nxt_state;
  logic [SEQ_W-1:0] nxt_seq;
  logic             hdr_ok;
  logic [SEQ_W-1:0] seq;
  logic             fwd;
  logic             err_inc;

  assign hdr_ok  = (bus_in[BUS_W-1 -: HDR_W] == HDR_VAL);
  assign seq     = bus_in[SEQ_W-1:0];
  assign fwd     = in_valid && ((nxt_state == S_FIRST_PKT) || (nxt_state == S_REG_PKT));
  assign err_inc = in_valid && is_err_state(nxt_state);
  assign control = state;

  // Next state and next expected sequence for the word on the bus; header error outranks sequence error.
  always_comb begin
    nxt_state = state;
    nxt_seq   = expected_seq;
    if (in_valid) begin
      case (state)
        S_IDLE: begin
          if (!hdr_ok) begin
            nxt_state = S_HDR_ERR;
          end else if (seq == '0) begin
            nxt_state = S_FIRST_PKT;
            nxt_seq   = SEQ_W'(1);
          end else begin
            nxt_state = S_SEQ_ERR;
          end
        end
        S_FIRST_PKT, S_REG_PKT: begin
          if (!hdr_ok) begin
            nxt_state = S_HDR_ERR;
          end else if (seq != expected_seq) begin
            nxt_state = S_SEQ_ERR;
          end else begin
            nxt_state = S_REG_PKT;
            nxt_seq   = expected_seq + SEQ_W'(1);
          end
        end
        S_HDR_ERR, S_SEQ_ERR: begin
          // With RESYNC_ANY clear, seq is 0 here so seq+1 gives the usual restart value of 1.
          if (hdr_ok && (RESYNC_ANY || (seq == '0))) begin
            nxt_state = S_FIRST_PKT;
            nxt_seq   = seq + SEQ_W'(1);
          end else if (!hdr_ok) begin
            nxt_state = S_HDR_ERR;
          end else begin
            nxt_state = S_SEQ_ERR;
          end
        end
        default: begin
          nxt_state = S_IDLE;
          nxt_seq   = '0;
        end
      endcase
    end
  end

  // Register state and every visible output together so they change on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      bus_out      <= '0;
      out_valid    <= 1'b0;
      error        <= 1'b0;
      expected_seq <= '0;
    end else begin
      state        <= nxt_state;
      expected_seq <= nxt_seq;
      error        <= is_err_state(nxt_state);
      out_valid    <= fwd;
      if (in_valid) begin
        bus_out <= fwd ? bus_in : '0;
      end
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (err_inc),
    .clr   (err_clr),
    .count (err_count)
  );

endmodule

// File: tb/tb_frame_seq_checker.sv
// Scoreboard bench: drivers queue hand-computed responses, a monitor pops and compares.
// Latency: expects each response one cycle after the word is presented.
// Backpressure: none.
module tb_frame_seq_checker;

  typedef struct packed {
    logic [2:0]  ctl;
    logic        err;
    logic        ov;
    logic [15:0] bo;
    logic [3:0]  es;
    logic [7:0]  cnt;
  } obs_t;

  typedef struct {
    string name;
    obs_t  e;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // DUT A: default parameters (strict resync, 8-bit counter)
  logic [15:0] a_bus_in = '0;
  logic        a_valid = 1'b0;
  logic        a_clr = 1'b0;
  logic [15:0] a_bus_out;
  logic        a_ov;
  logic [2:0]  a_ctl;
  logic        a_err;
  logic [3:0]  a_es;
  logic [7:0]  a_cnt;

  // DUT B: resync on any good header, 2-bit counter
  logic [15:0] b_bus_in = '0;
  logic        b_valid = 1'b0;
  logic        b_clr = 1'b0;
  logic [15:0] b_bus_out;
  logic        b_ov;
  logic [2:0]  b_ctl;
  logic        b_err;
  logic [3:0]  b_es;
  logic [1:0]  b_cnt;

  int compared = 0;
  int mismatched = 0;

  sb_t qa[$];
  sb_t qb[$];

  always #5 clk = ~clk;

  frame_seq_checker u_dut_a (
    .clk          (clk),
    .reset        (rst_n),
    .bus_in       (a_bus_in),
    .in_valid     (a_valid),
    .err_clr      (a_clr),
    .bus_out      (a_bus_out),
    .out_valid    (a_ov),
    .control      (a_ctl),
    .error        (a_err),
    .expected_seq (a_es),
    .err_count    (a_cnt)
  );

  frame_seq_checker #(
    .CNT_W      (2),
    .RESYNC_ANY (1'b1)
  ) u_dut_b (
    .clk          (clk),
    .reset        (rst_n),
    .bus_in       (b_bus_in),
    .in_valid     (b_valid),
    .err_clr      (b_clr),
    .bus_out      (b_bus_out),
    .out_valid    (b_ov),
    .control      (b_ctl),
    .error        (b_err),
    .expected_seq (b_es),
    .err_count    (b_cnt)
  );

  function automatic obs_t mk(input logic [2:0] ctl, input logic err, input logic ov,
                              input logic [15:0] bo, input logic [3:0] es, input logic [7:0] cnt);
    obs_t o;
    o.ctl = ctl; o.err = err; o.ov = ov; o.bo = bo; o.es = es; o.cnt = cnt;
    return o;
  endfunction

  function automatic obs_t obs_a();
    return mk(a_ctl, a_err, a_ov, a_bus_out, a_es, a_cnt);
  endfunction

  function automatic obs_t obs_b();
    return mk(b_ctl, b_err, b_ov, b_bus_out, b_es, {6'b0, b_cnt});
  endfunction

  task automatic cmp(input string name, input obs_t act, input obs_t exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got ctl=%0d err=%0d ov=%0d bo=%h es=%0d cnt=%0d, expected ctl=%0d err=%0d ov=%0d bo=%h es=%0d cnt=%0d",
               name, act.ctl, act.err, act.ov, act.bo, act.es, act.cnt,
               exp.ctl, exp.err, exp.ov, exp.bo, exp.es, exp.cnt);
    end
  endtask

  task automatic send_a(input string name, input logic v, input logic [15:0] w,
                        input logic clr, input obs_t e);
    sb_t s;
    @(negedge clk);
    a_valid = v; a_bus_in = w; a_clr = clr;
    s.name = name; s.e = e;
    qa.push_back(s);
  endtask

  task automatic send_b(input string name, input logic v, input logic [15:0] w,
                        input logic clr, input obs_t e);
    sb_t s;
    @(negedge clk);
    b_valid = v; b_bus_in = w; b_clr = clr;
    s.name = name; s.e = e;
    qb.push_back(s);
  endtask

  task automatic idle_all();
    @(negedge clk);
    a_valid = 1'b0; a_clr = 1'b0; a_bus_in = '0;
    b_valid = 1'b0; b_clr = 1'b0; b_bus_in = '0;
  endtask

  // Monitor: one queued response per presented cycle, checked just after the sampling edge.
  always @(posedge clk) begin
    sb_t s;
    #1;
    if (qa.size() > 0) begin
      s = qa.pop_front();
      cmp({"A.", s.name}, obs_a(), s.e);
    end
    if (qb.size() > 0) begin
      s = qb.pop_front();
      cmp({"B.", s.name}, obs_b(), s.e);
    end
  end

  initial begin
    logic [15:0] w;

    // Reset values
    #12;
    cmp("A.reset", obs_a(), mk(3'd0, 1'b0, 1'b0, 16'h0, 4'd0, 8'd0));
    cmp("B.reset", obs_b(), mk(3'd0, 1'b0, 1'b0, 16'h0, 4'd0, 8'd0));
    @(negedge clk);
    rst_n = 1'b1;

    // In-order stream from IDLE
    send_a("t1_w0", 1'b1, 16'hFAE0, 1'b0, mk(3'd1, 1'b0, 1'b1, 16'hFAE0, 4'd1, 8'd0));
    send_a("t1_w1", 1'b1, 16'hFAE1, 1'b0, mk(3'd2, 1'b0, 1'b1, 16'hFAE1, 4'd2, 8'd0));
    send_a("t1_w2", 1'b1, 16'hF0E2, 1'b0, mk(3'd2, 1'b0, 1'b1, 16'hF0E2, 4'd3, 8'd0));
    send_a("t1_w3", 1'b1, 16'hFA03, 1'b0, mk(3'd2, 1'b0, 1'b1, 16'hFA03, 4'd4, 8'd0));

    // Good word then bad header
    send_a("t2_seq4", 1'b1, 16'hF004, 1'b0, mk(3'd2, 1'b0, 1'b1, 16'hF004, 4'd5, 8'd0));
    send_a("t2_hdr", 1'b1, 16'h0AE5, 1'b0, mk(3'd3, 1'b1, 1'b0, 16'h0000, 4'd5, 8'd1));

    // Strict resync: nonzero seq stays in error, seq 0 restarts
    send_a("t3_seqerr", 1'b1, 16'hFAE7, 1'b0, mk(3'd4, 1'b1, 1'b0, 16'h0000, 4'd5, 8'd2));
    send_a("t3_resync", 1'b1, 16'hFAE0, 1'b0, mk(3'd1, 1'b0, 1'b1, 16'hFAE0, 4'd1, 8'd2));

    // Sequence wrap with idle gaps (bad-header garbage on the bus during gaps)
    for (int s = 1; s <= 17; s++) begin
      w = {4'hF, 8'h5A, 4'(s)};
      send_a("t4_seq", 1'b1, w, 1'b0, mk(3'd2, 1'b0, 1'b1, w, 4'(s + 1), 8'd2));
      if (s % 4 == 0)
        send_a("t4_gap", 1'b0, 16'h0123, 1'b0, mk(3'd2, 1'b0, 1'b0, w, 4'(s + 1), 8'd2));
    end
    idle_all();
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-cycle while in REG_PKT
    #2;
    rst_n = 1'b0;
    #1;
    cmp("A.async_reset", obs_a(), mk(3'd0, 1'b0, 1'b0, 16'h0, 4'd0, 8'd0));
    cmp("B.async_reset", obs_b(), mk(3'd0, 1'b0, 1'b0, 16'h0, 4'd0, 8'd0));
    @(negedge clk);
    rst_n = 1'b1;
    send_a("t6_first_seq3", 1'b1, 16'hFAE3, 1'b0, mk(3'd4, 1'b1, 1'b0, 16'h0000, 4'd0, 8'd1));
    send_a("t6_clr_idle", 1'b0, 16'hFAE0, 1'b1, mk(3'd4, 1'b1, 1'b0, 16'h0000, 4'd0, 8'd0));
    send_a("t6_clr_vs_inc", 1'b1, 16'h0AE5, 1'b1, mk(3'd3, 1'b1, 1'b0, 16'h0000, 4'd0, 8'd0));
    idle_all();

    // Saturation on 2-bit counter, then clear coincident with another errored word
    send_b("t5_bad1", 1'b1, 16'h0AE0, 1'b0, mk(3'd3, 1'b1, 1'b0, 16'h0, 4'd0, 8'd1));
    send_b("t5_bad2", 1'b1, 16'h0AE0, 1'b0, mk(3'd3, 1'b1, 1'b0, 16'h0, 4'd0, 8'd2));
    send_b("t5_bad3", 1'b1, 16'h0AE0, 1'b0, mk(3'd3, 1'b1, 1'b0, 16'h0, 4'd0, 8'd3));
    send_b("t5_bad4", 1'b1, 16'h0AE0, 1'b0, mk(3'd3, 1'b1, 1'b0, 16'h0, 4'd0, 8'd3));
    send_b("t5_bad5", 1'b1, 16'h0AE0, 1'b0, mk(3'd3, 1'b1, 1'b0, 16'h0, 4'd0, 8'd3));
    send_b("t5_clr", 1'b1, 16'h0AE0, 1'b1, mk(3'd3, 1'b1, 1'b0, 16'h0, 4'd0, 8'd0));

    // Any-header resync adopts the arriving sequence number
    send_b("t3b_adopt7", 1'b1, 16'hFAE7, 1'b0, mk(3'd1, 1'b0, 1'b1, 16'hFAE7, 4'd8, 8'd0));
    send_b("t3b_seq8", 1'b1, 16'hFAE8, 1'b0, mk(3'd2, 1'b0, 1'b1, 16'hFAE8, 4'd9, 8'd0));
    send_b("t3b_hdr", 1'b1, 16'h0AE0, 1'b0, mk(3'd3, 1'b1, 1'b0, 16'h0, 4'd9, 8'd1));
    send_b("t3b_adoptF", 1'b1, 16'hFAEF, 1'b0, mk(3'd1, 1'b0, 1'b1, 16'hFAEF, 4'd0, 8'd1));
    idle_all();

    // Every queued response must have been consumed
    repeat (3) @(negedge clk);
    compared++;
    if ((qa.size() != 0) || (qb.size() != 0)) begin
      mismatched++;
      $display("FAIL sb_drain: got %0d/%0d entries left, expected 0/0", qa.size(), qb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/frame_seq_checker.md
Name: frame_seq_checker

Overview:
- Parametrised packet-framing checker for a streamed word bus: validates a fixed header field and a rolling sequence number on each qualified word.
- Forwards good words, flags header and sequence errors, and resynchronises after an error.
- Counts errored words in a saturating counter.
- Sits between a word source and the downstream consumer; successor to the fixed 16-bit/4-bit-sequence frame machine, adding width/field parametrisation, input qualification, selectable resync mode and error statistics.

Parameters:
BUS_W, 16, bus word width
HDR_W, 4, header field width, located at bus_in[BUS_W-1 -: HDR_W]
HDR_VAL, 4'hF, required header value
SEQ_W, 4, sequence field width, located at bus_in[SEQ_W-1:0]
CNT_W, 8, error counter width
RESYNC_ANY, 0, 0: leave error only on good header with seq==0; 1: leave error on any good header, adopting its seq

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
bus_in  in  BUS_W  input word
in_valid  in  1  bus_in qualifier
err_clr  in  1  synchronous clear of err_count
bus_out  out  BUS_W  registered forwarded word
out_valid  out  1  bus_out qualifier
control  out  3  current state code
error  out  1  high while in an error state
expected_seq  out  SEQ_W  next expected sequence number
err_count  out  CNT_W  saturating count of errored words

Behaviour:
- Reset (reset=0, async): state=IDLE; bus_out=0; out_valid=0; error=0; expected_seq=0; err_count=0.
- State codes: IDLE=0, FIRST_PKT=1, REG_PKT=2, HDR_ERR=3, SEQ_ERR=4.
- All outputs are registered; the response appears on the clock edge that samples the word (1-cycle latency).
- in_valid=0: state, expected_seq and err_count hold (err_clr still acts); out_valid=0; bus_out holds.
- hdr_ok = (header field == HDR_VAL); seq = bus_in[SEQ_W-1:0]. A header error takes priority over a sequence error.
- IDLE:
  - hdr_ok & seq==0 -> FIRST_PKT, expected_seq=1.
  - !hdr_ok -> HDR_ERR.
  - hdr_ok & seq!=0 -> SEQ_ERR.
- FIRST_PKT / REG_PKT:
  - !hdr_ok -> HDR_ERR.
  - seq!=expected_seq -> SEQ_ERR.
  - Otherwise -> REG_PKT, expected_seq+1 modulo 2^SEQ_W (wraps from max to 0).
- HDR_ERR / SEQ_ERR:
  - RESYNC_ANY=0: hdr_ok & seq==0 -> FIRST_PKT, expected_seq=1.
  - RESYNC_ANY=1: any hdr_ok word -> FIRST_PKT, expected_seq=seq+1.
  - Any other valid word: an errored word. !hdr_ok -> HDR_ERR; otherwise -> SEQ_ERR. Error state may change between the two.
- Forwarding: a valid word whose next state is FIRST_PKT or REG_PKT sets bus_out=bus_in and out_valid=1. Any other valid word sets bus_out=0 and out_valid=0.
- error = 1 iff the registered state is HDR_ERR or SEQ_ERR.
- expected_seq holds while in error states.
- err_count increments by 1 per valid word whose next state is an error state, saturating at 2^CNT_W-1.
- err_clr: err_count=0 on the next edge; clear wins over a simultaneous increment.
- Reset asserted mid-packet returns to IDLE immediately with all reset values. The first word after reset release must carry seq 0.

Decomposition:
- Package frame_pkg: state-code localparams (IDLE..SEQ_ERR), STATE_W=3.
- One sub-module, sat_counter (CNT_W, inc, clr, async active-low reset), instantiated for err_count.
- Field extraction and next-state logic stay in frame_seq_checker.

Test Plan:
1. Reset, then valid words 16'hFAE0, FAE1, F0E2, FA03.
   -> control 1,2,2,2; bus_out echoes each word one cycle later; out_valid=1; error=0; expected_seq=4.
2. After (1), word 16'hF004 (seq 4 ok), then 16'h0AE5 (bad header).
   -> REG_PKT, then HDR_ERR: error=1, out_valid=0, bus_out=0, err_count=1.
3. RESYNC_ANY=0, in HDR_ERR: words 16'hFAE7, then 16'hFAE0.
   -> SEQ_ERR (err_count+1), then FIRST_PKT with expected_seq=1.
   RESYNC_ANY=1: 16'hFAE7 -> FIRST_PKT, expected_seq=8.
4. Stream seq 0..15 then 0 with in_valid gaps inserted.
   -> wrap 15->0 accepted with no error; state and outputs hold during gaps.
5. CNT_W=2, feed 5 bad-header words, then err_clr coincident with a 6th.
   -> err_count saturates at 3, then reads 0.
6. Assert reset for 1 cycle while in REG_PKT.
   -> asynchronous return to IDLE, all outputs 0. The next word 16'hFAE3 -> SEQ_ERR.
